// File: rtl/fuzz_round_sequencer.sv
// fuzz_round_sequencer: clocked controller for one fuzzing round.
// Holds the core in reset, releases it, and supervises the run until a tohost
// pass or the cycle budget ends the round. Coverage stagnation or watchdog
// expiry raise the MSIP nudge interrupt. At round end the status is reported
// and the block waits for the host to continue or stop.
//
// Optional build macro FUZZ_ROUND_STATS_EN adds nudge_count and
// last_round_cycles outputs; without it those ports and their logic are absent.
//
// Host handshake: host_ack is a single-cycle decision strobe, acted on only
// while the FSM is in WAIT_HOST (state_dbg == 3). host_continue is qualified by
// host_ack and ignored otherwise. The block is always ready in WAIT_HOST, so
// the decision is consumed on the same clock edge that samples host_ack.
module fuzz_round_sequencer #(
   parameter int COV_W      = 30,
   parameter int CNT_W      = 64,
   parameter int MAX_WAIT   = 1000,
   parameter int WATCHDOG   = 50000,
   parameter int MAX_CYCLES = 200000,
   parameter int RESET_HOLD = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [COV_W-1:0] cov,
   input  logic [63:0]      tohost,
   input  logic             host_ack,
   input  logic             host_continue,
   output logic             core_reset,
   output logic             interrupt,
   output logic             round_done,
   output logic [1:0]       round_status,
   output logic [CNT_W-1:0] cycle_count,
`ifdef FUZZ_ROUND_STATS_EN
   output logic [31:0]      nudge_count,
   output logic [CNT_W-1:0] last_round_cycles,
`endif
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {
      S_HOLD      = 3'd0,
      S_RUN       = 3'd1,
      S_END       = 3'd2,
      S_WAIT_HOST = 3'd3,
      S_HALT      = 3'd4
   } state_t;

   localparam int HOLD_W = $clog2(RESET_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

   localparam logic [1:0] ST_NONE    = 2'b00;
   localparam logic [1:0] ST_PASS    = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;
   localparam logic [1:0] ST_HALTED  = 2'b11;

   state_t             state;
   state_t             state_nxt;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [CNT_W-1:0]   stall_cnt;
   logic [CNT_W-1:0]   wd_cnt;
   logic [COV_W-1:0]   pre_cov;

   logic [CNT_W-1:0]   cycle_inc;
   logic [CNT_W-1:0]   stall_inc;
   logic [CNT_W-1:0]   wd_inc;
   logic [CNT_W-1:0]   stall_limit;
   logic               pass_hit;
   logic               budget_hit;

   // Only the pass bit of tohost is meaningful to this block.
   logic               unused_tohost;
   assign unused_tohost = ^tohost[63:1];

   // Saturating increments: counters stick at all-ones instead of wrapping.
   assign cycle_inc = (cycle_count == '1) ? cycle_count : cycle_count + 1'b1;
   assign stall_inc = (stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1;
   assign wd_inc    = (wd_cnt == '1) ? wd_cnt : wd_cnt + 1'b1;

   // Stagnation window widens with coverage: MAX_WAIT * ((cov >> 19) + 1) at CNT_W bits.
   assign stall_limit = CNT_W'(MAX_WAIT) * (CNT_W'(cov >> 19) + 1'b1);

   // Nudge interrupt from the registered counters, only while the core runs.
   assign interrupt = (state == S_RUN) &&
                      ((stall_cnt >= stall_limit) || (wd_cnt >= CNT_W'(WATCHDOG)));

   assign state_dbg = state;

   // State register.
   always_ff @(posedge clock) begin
      if (reset) state <= S_HOLD;
      else       state <= state_nxt;
   end

   // Next-state and per-state outputs. The budget counts the exit cycle
   // itself, so a timed-out round reports exactly MAX_CYCLES run cycles.
   always_comb begin
      state_nxt  = state;
      core_reset = 1'b1;
      round_done = 1'b0;
      pass_hit   = 1'b0;
      budget_hit = 1'b0;
      case (state)
         S_HOLD: begin
            if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
         end
         S_RUN: begin
            core_reset = 1'b0;
            pass_hit   = tohost[0];
            budget_hit = (MAX_CYCLES != 0) && (cycle_inc >= CNT_W'(MAX_CYCLES));
            if (pass_hit || budget_hit) state_nxt = S_END;
         end
         S_END: begin
            round_done = 1'b1;
            state_nxt  = S_WAIT_HOST;
         end
         S_WAIT_HOST: begin
            if (host_ack) state_nxt = host_continue ? S_HOLD : S_HALT;
         end
         S_HALT: begin
            state_nxt = S_HALT;
         end
         default: begin
            state_nxt = S_HOLD;
         end
      endcase
   end

   // Round datapath: hold timer, run counters, coverage tracking, status.
   always_ff @(posedge clock) begin
      if (reset) begin
         hold_cnt     <= '0;
         cycle_count  <= '0;
         stall_cnt    <= '0;
         wd_cnt       <= '0;
         pre_cov      <= '0;
         round_status <= ST_NONE;
      end else begin
         case (state)
            S_HOLD: begin
               hold_cnt    <= hold_cnt + 1'b1;
               cycle_count <= '0;
               stall_cnt   <= '0;
               wd_cnt      <= '0;
               pre_cov     <= '0;
            end
            S_RUN: begin
               cycle_count <= cycle_inc;
               wd_cnt      <= wd_inc;
               if (cov != pre_cov) begin
                  pre_cov   <= cov;
                  stall_cnt <= '0;
               end else begin
                  stall_cnt <= stall_inc;
               end
               if (pass_hit) begin
                  stall_cnt    <= '0;
                  wd_cnt       <= '0;
                  round_status <= ST_PASS;
               end else if (budget_hit) begin
                  round_status <= ST_TIMEOUT;
               end
            end
            S_WAIT_HOST: begin
               if (host_ack) begin
                  if (host_continue) begin
                     hold_cnt     <= '0;
                     cycle_count  <= '0;
                     stall_cnt    <= '0;
                     wd_cnt       <= '0;
                     pre_cov      <= '0;
                     round_status <= ST_NONE;
                  end else begin
                     round_status <= ST_HALTED;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef FUZZ_ROUND_STATS_EN
   logic irq_q;

   // Per-round statistics: interrupt rising edges and the final run length.
   always_ff @(posedge clock) begin
      if (reset) begin
         irq_q             <= 1'b0;
         nudge_count       <= '0;
         last_round_cycles <= '0;
      end else begin
         irq_q <= interrupt;
         if ((state == S_HOLD) || (state_nxt == S_HOLD)) begin
            nudge_count <= '0;
         end else if (interrupt && !irq_q && (nudge_count != '1)) begin
            nudge_count <= nudge_count + 1'b1;
         end
         if ((state == S_RUN) && (state_nxt == S_END)) begin
            last_round_cycles <= cycle_inc;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fuzz_round_sequencer.sv
// Directed bench for fuzz_round_sequencer with shortened watchdog and budget.
// RUN cycles are numbered from 1; in RUN cycle n the registered counters hold n-1.
module tb_fuzz_round_sequencer;

   localparam int COV_W      = 30;
   localparam int CNT_W      = 64;
   localparam int MAX_WAIT   = 1000;
   localparam int WATCHDOG   = 8000;
   localparam int MAX_CYCLES = 12000;
   localparam int RESET_HOLD = 4;

   localparam logic [COV_W-1:0] COV_HI  = 30'h0018_0000;  // 3 << 19
   localparam logic [63:0]      NO_PASS = 64'hFFFF_0000_0000_0002;

   logic             clock;
   logic             reset;
   logic [COV_W-1:0] cov;
   logic [63:0]      tohost;
   logic             host_ack;
   logic             host_continue;
   logic             core_reset;
   logic             interrupt;
   logic             round_done;
   logic [1:0]       round_status;
   logic [CNT_W-1:0] cycle_count;
   logic [2:0]       state_dbg;
`ifdef FUZZ_ROUND_STATS_EN
   logic [31:0]      nudge_count;
   logic [CNT_W-1:0] last_round_cycles;
`endif

   int vectors    = 0;
   int miscompares = 0;

   fuzz_round_sequencer #(
      .COV_W(COV_W), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT), .WATCHDOG(WATCHDOG),
      .MAX_CYCLES(MAX_CYCLES), .RESET_HOLD(RESET_HOLD)
   ) dut (
      .clock(clock),
      .reset(reset),
      .cov(cov),
      .tohost(tohost),
      .host_ack(host_ack),
      .host_continue(host_continue),
      .core_reset(core_reset),
      .interrupt(interrupt),
      .round_done(round_done),
      .round_status(round_status),
      .cycle_count(cycle_count),
`ifdef FUZZ_ROUND_STATS_EN
      .nudge_count(nudge_count),
      .last_round_cycles(last_round_cycles),
`endif
      .state_dbg(state_dbg)
   );

   // Clock and global time limit.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation time limit reached, required finish before it");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // From the first HOLD cycle, count core_reset cycles until RUN (bounded).
   task automatic hold_then_run(input string tag);
      int held = 0;
      bit found = 0;
      for (int i = 0; i < 20; i++) begin
         if (core_reset === 1'b0) begin
            found = 1;
            break;
         end
         held++;
         tick();
      end
      vectors++;
      if (!found || held != RESET_HOLD) begin
         miscompares++;
         $display("FAIL %s_hold_len: got %0d held cycles (found=%0d), want %0d", tag, held, found, RESET_HOLD);
      end
      vectors++;
      if (cycle_count !== 0) begin
         miscompares++;
         $display("FAIL %s_run_start_count: got %0d, want 0", tag, cycle_count);
      end
   endtask

   task automatic check_end(input string tag, input logic [1:0] st, input int cnt);
      vectors++;
      if (round_done !== 1'b1 || round_status !== st || cycle_count !== CNT_W'(cnt) || core_reset !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_end: done=%b status=%b count=%0d core_reset=%b, want 1 %b %0d 1",
                  tag, round_done, round_status, cycle_count, core_reset, st, cnt);
      end
   endtask

   task automatic ack_continue(input string tag);
      host_ack = 1'b1;
      host_continue = 1'b1;
      tick();
      host_ack = 1'b0;
      host_continue = 1'b0;
      vectors++;
      if (round_status !== 2'b00 || cycle_count !== 0 || core_reset !== 1'b1 || state_dbg !== 3'd0) begin
         miscompares++;
         $display("FAIL %s_restart: status=%b count=%0d core_reset=%b state=%0d, want 00 0 1 0",
                  tag, round_status, cycle_count, core_reset, state_dbg);
      end
      hold_then_run(tag);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cov = '0;
      tohost = '0;
      host_ack = 1'b0;
      host_continue = 1'b0;
      tick();
      tick();
      vectors++;
      if (core_reset !== 1'b1 || interrupt !== 1'b0 || round_done !== 1'b0 ||
          round_status !== 2'b00 || cycle_count !== 0) begin
         miscompares++;
         $display("FAIL reset_values: core_reset=%b irq=%b done=%b status=%b count=%0d, want 1 0 0 00 0",
                  core_reset, interrupt, round_done, round_status, cycle_count);
      end
      reset = 1'b0;
      hold_then_run("reset");
   endtask

   // Pass at registered count 100; host_ack with stop during RUN must be ignored.
   task automatic test_pass_round();
      int irq_seen = 0;
      int bad_track = 0;
      for (int k = 0; k < 100; k++) begin
         cov = 30'd5;
         tohost = NO_PASS;
         host_ack = (k % 7 == 3);
         host_continue = 1'b0;
         #1;
         if (interrupt) irq_seen++;
         if (cycle_count !== CNT_W'(k) || core_reset !== 1'b0 || round_done !== 1'b0) bad_track++;
         tick();
      end
      host_ack = 1'b0;
      tohost = 64'h1;
      #1;
      if (interrupt) irq_seen++;
      tick();
      tohost = '0;
      vectors++;
      if (irq_seen != 0) begin
         miscompares++;
         $display("FAIL pass_no_irq: interrupt high in %0d cycles, want 0", irq_seen);
      end
      vectors++;
      if (bad_track != 0) begin
         miscompares++;
         $display("FAIL pass_count_track: %0d bad run cycles, want 0", bad_track);
      end
      check_end("pass", 2'b01, 101);
      tick();
      vectors++;
      if (round_done !== 1'b0 || round_status !== 2'b01 || state_dbg !== 3'd3) begin
         miscompares++;
         $display("FAIL pass_pulse_len: done=%b status=%b state=%0d, want 0 01 3", round_done, round_status, state_dbg);
      end
   endtask

   task automatic test_wait_host();
      int bad = 0;
      for (int i = 0; i < 20; i++) begin
         host_ack = 1'b0;
         host_continue = i[0];
         tohost = 64'h1;
         cov = COV_W'(i);
         #1;
         if (core_reset !== 1'b1 || round_done !== 1'b0 || interrupt !== 1'b0 ||
             round_status !== 2'b01 || cycle_count !== 101 || state_dbg !== 3'd3) bad++;
         tick();
      end
      tohost = '0;
      cov = '0;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL wait_host_idle: %0d bad cycles, want 0", bad);
      end
      ack_continue("wait_host");
   endtask

   // Frozen coverage: rises at 1001, cov change at 1500 drops it at 1501,
   // then cov = 3<<19 frozen widens the window to 4000 (rise at 5502).
   task automatic test_stagnation();
      int bad = 0;
      int first_rise = 0;
      int second_rise = 0;
      logic exp_irq;
      for (int n = 1; n <= 5503; n++) begin
         cov = (n < 1500) ? 30'd0 : ((n == 1500) ? 30'd1 : COV_HI);
         tohost = (n == 5503) ? 64'h1 : NO_PASS;
         exp_irq = ((n >= 1001) && (n <= 1500)) || (n >= 5502);
         #1;
         if (interrupt === 1'b1 && first_rise == 0) first_rise = n;
         if (interrupt === 1'b1 && n > 1500 && second_rise == 0) second_rise = n;
         if (interrupt !== exp_irq || core_reset !== 1'b0) bad++;
         tick();
      end
      tohost = '0;
      vectors++;
      if (first_rise != 1001) begin
         miscompares++;
         $display("FAIL stall_first_rise: got cycle %0d, want 1001", first_rise);
      end
      vectors++;
      if (second_rise != 5502) begin
         miscompares++;
         $display("FAIL stall_scaled_rise: got cycle %0d, want 5502", second_rise);
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL stall_trace: %0d bad cycles, want 0", bad);
      end
      check_end("stall", 2'b01, 5503);
`ifdef FUZZ_ROUND_STATS_EN
      vectors++;
      if (nudge_count !== 32'd2 || last_round_cycles !== 5503) begin
         miscompares++;
         $display("FAIL stall_stats: nudges=%0d last=%0d, want 2 5503", nudge_count, last_round_cycles);
      end
`endif
      tick();
      ack_continue("stall");
   endtask

   // Coverage toggles every cycle: watchdog rises at 8001, budget ends at 12000.
   // With pass_at_end the pass arrives in the budget's final cycle and must win.
   task automatic run_budget(input string tag, input bit pass_at_end, input logic [1:0] st);
      int bad = 0;
      int first_rise = 0;
      for (int n = 1; n <= MAX_CYCLES; n++) begin
         cov = n[0] ? 30'd1 : 30'd2;
         tohost = (pass_at_end && n == MAX_CYCLES) ? 64'h1 : NO_PASS;
         #1;
         if (interrupt === 1'b1 && first_rise == 0) first_rise = n;
         if (interrupt !== (n >= WATCHDOG + 1) || core_reset !== 1'b0) bad++;
         tick();
      end
      tohost = '0;
      vectors++;
      if (first_rise != WATCHDOG + 1) begin
         miscompares++;
         $display("FAIL %s_wd_rise: got cycle %0d, want %0d", tag, first_rise, WATCHDOG + 1);
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL %s_trace: %0d bad cycles, want 0", tag, bad);
      end
      check_end(tag, st, MAX_CYCLES);
      tick();
   endtask

   task automatic test_timeout();
      run_budget("timeout", 1'b0, 2'b10);
      ack_continue("timeout");
   endtask

   task automatic test_pass_wins_and_halt();
      int bad = 0;
      run_budget("tie", 1'b1, 2'b01);
      host_ack = 1'b1;
      host_continue = 1'b0;
      tick();
      vectors++;
      if (round_status !== 2'b11 || core_reset !== 1'b1 || state_dbg !== 3'd4 || round_done !== 1'b0) begin
         miscompares++;
         $display("FAIL halt_entry: status=%b core_reset=%b state=%0d done=%b, want 11 1 4 0",
                  round_status, core_reset, state_dbg, round_done);
      end
      for (int i = 0; i < 6; i++) begin
         host_ack = 1'b1;
         host_continue = 1'b1;
         tohost = 64'h1;
         #1;
         if (round_status !== 2'b11 || core_reset !== 1'b1 || state_dbg !== 3'd4) bad++;
         tick();
      end
      host_ack = 1'b0;
      host_continue = 1'b0;
      tohost = '0;
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL halt_sticky: %0d bad cycles, want 0", bad);
      end
   endtask

   task automatic test_reset_mid_run();
      int dones = 0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      hold_then_run("halt_exit");
      for (int n = 1; n <= 500; n++) begin
         cov = '0;
         tohost = NO_PASS;
         if (n == 500) reset = 1'b1;
         #1;
         if (round_done) dones++;
         tick();
      end
      reset = 1'b0;
      #1;
      if (round_done) dones++;
      vectors++;
      if (dones != 0 || cycle_count !== 0 || round_status !== 2'b00 ||
          core_reset !== 1'b1 || interrupt !== 1'b0 || state_dbg !== 3'd0) begin
         miscompares++;
         $display("FAIL midrun_reset: dones=%0d count=%0d status=%b core_reset=%b irq=%b state=%0d, want 0 0 00 1 0 0",
                  dones, cycle_count, round_status, core_reset, interrupt, state_dbg);
      end
`ifdef FUZZ_ROUND_STATS_EN
      vectors++;
      if (nudge_count !== 32'd0) begin
         miscompares++;
         $display("FAIL midrun_nudges: got %0d, want 0", nudge_count);
      end
`endif
      hold_then_run("midrun");
   endtask

   initial begin
      test_reset();
      test_pass_round();
      test_wait_host();
      test_stagnation();
      test_timeout();
      test_pass_wins_and_halt();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
